// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame link: receiver FSM encoding,
// parity sense constants and a small index-width helper.
package parity_frame_rx_pkg;

    // Receiver FSM states; encoding is shared with the generator side.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Parity sense: required XOR of data plus parity bit.
    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Bundle of the receiver's serial input and captured-word outputs.
//   master : drives bit_en/rx, observes data_out/valid/par_err/frame_err/err_cnt
//   slave  : the receiver itself
interface parity_frame_rx_if #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned CNT_W  = 8
);
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              par_err;
    logic              frame_err;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output bit_en, rx,
        input  data_out, valid, par_err, frame_err, err_cnt
    );

    modport slave (
        input  bit_en, rx,
        output data_out, valid, par_err, frame_err, err_cnt
    );
endinterface

// File: rtl/parity_frame_rx_parity_fold.sv
// Combinational XOR reduction: par_c = 1 when bits_i holds an odd number
// of ones. Shared with the transmitter for parity generation.
//   bits_i : W-bit vector (data plus parity bit on the receive side)
//   par_c  : ones-count parity of bits_i
module parity_fold #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] bits_i,
    output logic         par_c
);
    assign par_c = ^bits_i;
endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / parity /
// stop. Recomputes parity, flags parity and framing errors, and counts
// parity-error frames in a saturating counter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bit_en/rx in; data_out, valid, par_err, frame_err, err_cnt out
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_W  = 3,
    parameter bit          ODD_PAR = PAR_ODD,
    parameter int unsigned CNT_W   = 8
) (
    input logic            clk,
    input logic            rst,
    parity_frame_rx_if.slave bus
);
    localparam int unsigned      IDX_W    = idx_w(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [DATA_W-1:0]   shift_q,     shift_d;
    logic                par_bit_q,   par_bit_d;
    logic [DATA_W-1:0]   data_out_q,  data_out_d;
    logic                valid_q,     valid_d;
    logic                par_err_q,   par_err_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
    logic                par_c;
    logic                par_mis_c;

    // Parity over the complete frame payload; only consulted in STOP.
    parity_fold #(.W(DATA_W + 1)) u_fold (
        .bits_i ({par_bit_q, shift_q}),
        .par_c  (par_c)
    );

    assign par_mis_c = (par_c != ODD_PAR);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next state; everything holds unless a bit strobe arrives, except
    // valid which is a single-cycle pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        err_cnt_d   = err_cnt_q;

        if (bus.bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.rx) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        shift_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d[idx_q] = bus.rx;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_bit_d = bus.rx;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    state_d     = ST_IDLE;
                    data_out_d  = shift_q;
                    par_err_d   = par_mis_c;
                    frame_err_d = ~bus.rx;
                    valid_d     = 1'b1;
                    if (par_mis_c && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid     = valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx (DATA_W=3, odd parity, 8-bit
// error counter). A frame-level model queues the expected result of every
// complete frame sent; a negedge monitor checks the outputs every cycle.
module tb_parity_frame_rx;
    localparam int unsigned DW  = 3;
    localparam int unsigned CW  = 8;
    localparam bit          ODD = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parity_frame_rx_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    parity_frame_rx #(.DATA_W(DW), .ODD_PAR(ODD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   model_cnt;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        last.data = '0;
        last.perr = 1'b0;
        last.ferr = 1'b0;
        last.cnt  = '0;
        model_cnt = 0;
    endfunction

    // Expected result of a frame from the link's rules.
    function automatic void push_frame(input logic [DW-1:0] d, input logic p, input logic s);
        exp_t e;
        logic ones_odd;
        ones_odd = (($countones({d, p}) % 2) == 1);
        e.data   = d;
        e.perr   = (ones_odd != ODD);
        e.ferr   = ~s;
        if (e.perr && model_cnt < 255) model_cnt++;
        e.cnt    = CW'(model_cnt);
        exp_q.push_back(e);
    endfunction

    // Per-cycle monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1, expected no pending frame (t=%0t)", $time);
                end else begin
                    last = exp_q.pop_front();
                end
            end
            chk("data_out",  32'(bus.data_out),  32'(last.data));
            chk("par_err",   32'(bus.par_err),   32'(last.perr));
            chk("frame_err", 32'(bus.frame_err), 32'(last.ferr));
            chk("err_cnt",   32'(bus.err_cnt),   32'(last.cnt));
        end
    end

    task automatic drive(input logic en, input logic r);
        @(posedge clk);
        #1;
        bus.bit_en = en;
        bus.rx     = r;
    endtask

    // One bit cell: strobe on the last cycle of the period.
    task automatic send_bit(input logic b, input int period, input bit noise);
        for (int k = 0; k < period; k++) begin
            if (k == period - 1) drive(1'b1, b);
            else drive(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input int period, input bit noise);
        push_frame(d, p, s);
        send_bit(1'b0, period, noise);
        for (int i = 0; i < int'(DW); i++) send_bit(d[i], period, noise);
        send_bit(p, period, noise);
        send_bit(s, period, noise);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1);
    endtask

    // Bounded wait for every queued frame to be reported.
    task automatic drain(input string nm);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(posedge clk);
            w++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d frame(s) never reported, expected 0", nm, exp_q.size());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"},     32'(bus.valid),     32'd0);
        chk({nm, "_data_out"},  32'(bus.data_out),  32'd0);
        chk({nm, "_par_err"},   32'(bus.par_err),   32'd0);
        chk({nm, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        chk({nm, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.bit_en = 1'b0;
        bus.rx     = 1'b1;
        @(posedge clk);
        #2;
        model_reset();
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.bit_en = 1'b0;
        bus.rx     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        #1;
        rst = 1'b0;
        idle(2);

        // 1: clean frame 3'b011, parity 1.
        send_frame(3'b011, 1'b1, 1'b1, 1, 1'b0);
        idle(2);
        drain("t1_drain");
        chk("t1_data",  32'(bus.data_out),  32'h3);
        chk("t1_perr",  32'(bus.par_err),   32'h0);
        chk("t1_ferr",  32'(bus.frame_err), 32'h0);
        chk("t1_cnt",   32'(bus.err_cnt),   32'd0);

        // 2: bad parity once, then until the counter saturates.
        send_frame(3'b011, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        drain("t2_drain_a");
        chk("t2_data",  32'(bus.data_out), 32'h3);
        chk("t2_perr",  32'(bus.par_err),  32'h1);
        chk("t2_cnt1",  32'(bus.err_cnt),  32'd1);
        for (int i = 1; i < 300; i++) send_frame(3'b011, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        drain("t2_drain_b");
        chk("t2_cnt_sat", 32'(bus.err_cnt), 32'd255);

        // 3: framing error, good parity.
        send_frame(3'b000, 1'b1, 1'b0, 1, 1'b0);
        idle(3);
        drain("t3_drain");
        chk("t3_data", 32'(bus.data_out),  32'h0);
        chk("t3_perr", 32'(bus.par_err),   32'h0);
        chk("t3_ferr", 32'(bus.frame_err), 32'h1);
        chk("t3_cnt",  32'(bus.err_cnt),   32'd255);

        // 4: sparse strobes with noise between them.
        send_frame(3'b101, 1'b1, 1'b1, 4, 1'b1);
        idle(2);
        drain("t4_drain");
        chk("t4_data", 32'(bus.data_out),  32'h5);
        chk("t4_perr", 32'(bus.par_err),   32'h0);
        chk("t4_ferr", 32'(bus.frame_err), 32'h0);

        // 5: reset after d1 aborts the frame; then a clean frame.
        send_bit(1'b0, 1, 1'b0);
        send_bit(1'b0, 1, 1'b0);
        send_bit(1'b1, 1, 1'b0);
        do_reset();
        idle(4);
        send_frame(3'b110, 1'b1, 1'b1, 1, 1'b0);
        idle(2);
        drain("t5_drain");
        chk("t5_data", 32'(bus.data_out), 32'h6);
        chk("t5_perr", 32'(bus.par_err),  32'h0);
        chk("t5_cnt",  32'(bus.err_cnt),  32'd0);

        // 6: back-to-back frames with no idle bits.
        send_frame(3'b001, 1'b0, 1'b1, 1, 1'b0);
        send_frame(3'b111, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        drain("t6_drain");
        chk("t6_data", 32'(bus.data_out), 32'h7);
        chk("t6_perr", 32'(bus.par_err),  32'h0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
